// File: rtl/buffer_line_pkg.sv
// buffer_line_pkg
// Shared types and constants for the buffer-line sink.
//   entry_t           : one queued {addr, data} pair at the default line widths
//   MATCH_COUNT_WIDTH : width of the saturating data_just_matched counter
package buffer_line_pkg;

  localparam int ENTRY_ADDR_WIDTH  = 8;
  localparam int ENTRY_DATA_WIDTH  = 32;
  localparam int MATCH_COUNT_WIDTH = 16;

  typedef struct packed {
    logic [ENTRY_ADDR_WIDTH-1:0] addr;
    logic [ENTRY_DATA_WIDTH-1:0] data;
  } entry_t;

endpackage

// File: rtl/buffer_line_interface.sv
// buffer_line_interface
// Producer -> consumer handshake of a buffer line. The producer holds addr/data
// and their valids until it sees ack.
//   addr, addr_valid, data, data_valid, data_just_matched : producer -> consumer
//   ack                                                    : consumer -> producer
interface buffer_line_interface #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  data_just_matched;
  logic                  ack;

  modport producer (
    output addr, addr_valid, data, data_valid, data_just_matched,
    input  ack
  );

  modport consumer (
    input  addr, addr_valid, data, data_valid, data_just_matched,
    output ack
  );
endinterface

// File: rtl/buffer_line_fifo.sv
// buffer_line_fifo
// Generic synchronous FIFO, no pass-through, head read straight from storage.
//   clk, reset  : clock and synchronous active-high reset (flushes contents)
//   i_push      : write i_wr_data (ignored when full)
//   i_pop       : retire the head entry (ignored when empty)
//   o_rd_data   : entry at the read pointer
//   o_full, o_empty, o_count : occupancy status
module buffer_line_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full && !reset;
  assign w_pop   = i_pop && !o_empty;

  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage needs no reset: the flush is done by clearing pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/buffer_line_sink.sv
// buffer_line_sink
// Consumer endpoint of a buffer line: acknowledges (addr, data) pairs, queues
// them, and drains them as a valid/ready stream toward the local buffer.
//   clk, reset    : clock and synchronous active-high reset
//   in            : buffer_line_interface consumer side (ack driven here)
//   out_addr/data : FIFO head, meaningful while out_valid
//   out_valid     : FIFO non-empty
//   out_ready     : downstream takes the head entry
//   match_count   : saturating count of accepted pairs with data_just_matched
//   protocol_err  : sticky hold-rule violation flag
// Optional feature: define BUFFER_LINE_CHECK_EN to build the hold-rule checker;
// otherwise protocol_err is constant 0.
module buffer_line_sink
  import buffer_line_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  buffer_line_interface.consumer       in,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MATCH_COUNT_WIDTH-1:0] match_count,
  output logic                         protocol_err
);
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic                         w_ack;
  logic                         w_full;
  logic                         w_empty;
  logic [CNT_W-1:0]             w_count;
  logic [ENTRY_W-1:0]           w_rd_entry;
  logic [MATCH_COUNT_WIDTH-1:0] r_match_count;

  // No bypass when full: ack never depends on out_ready.
  assign w_ack  = in.addr_valid && in.data_valid && !w_full && !reset;
  assign in.ack = w_ack;

  buffer_line_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_ack),
    .i_wr_data ({in.addr, in.data}),
    .i_pop     (out_valid && out_ready),
    .o_rd_data (w_rd_entry),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign out_valid = !w_empty;
  assign out_addr  = w_rd_entry[ENTRY_W-1:DATA_WIDTH];
  assign out_data  = w_rd_entry[DATA_WIDTH-1:0];

  always_comb begin
    assert (w_full == (w_count == CNT_W'(DEPTH)) && w_empty == (w_count == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_match_count <= '0;
    end else if (w_ack && in.data_just_matched && (r_match_count != '1)) begin
      r_match_count <= r_match_count + 1'b1;
    end
  end
  assign match_count = r_match_count;

`ifdef BUFFER_LINE_CHECK_EN
  logic [ADDR_WIDTH-1:0] r_prev_addr;
  logic [DATA_WIDTH-1:0] r_prev_data;
  logic                  r_prev_addr_valid;
  logic                  r_prev_data_valid;
  logic                  r_prev_ack;
  logic                  r_protocol_err;
  logic                  w_addr_violation;
  logic                  w_data_violation;

  // An unacked valid from last cycle must persist with the same payload.
  assign w_addr_violation = r_prev_addr_valid && !r_prev_ack &&
                            (!in.addr_valid || (in.addr != r_prev_addr));
  assign w_data_violation = r_prev_data_valid && !r_prev_ack &&
                            (!in.data_valid || (in.data != r_prev_data));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_addr       <= '0;
      r_prev_data       <= '0;
      r_prev_addr_valid <= 1'b0;
      r_prev_data_valid <= 1'b0;
      r_prev_ack        <= 1'b0;
      r_protocol_err    <= 1'b0;
    end else begin
      r_prev_addr       <= in.addr;
      r_prev_data       <= in.data;
      r_prev_addr_valid <= in.addr_valid;
      r_prev_data_valid <= in.data_valid;
      r_prev_ack        <= w_ack;
      if (w_addr_violation || w_data_violation) r_protocol_err <= 1'b1;
    end
  end
  assign protocol_err = r_protocol_err;
`else
  assign protocol_err = 1'b0;
`endif
endmodule

// File: tb/tb_buffer_line_sink.sv
// tb_buffer_line_sink
// Directed-vector bench for buffer_line_sink at ADDR_WIDTH=8, DATA_WIDTH=32, DEPTH=4.
module tb_buffer_line_sink;
  logic        clk;
  logic        reset;
  logic [7:0]  out_addr;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] match_count;
  logic        protocol_err;

  int n_checks;
  int n_fail;

`ifdef BUFFER_LINE_CHECK_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  buffer_line_interface #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bl_if ();

  buffer_line_sink #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (bl_if),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .match_count  (match_count),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input logic av, input logic [7:0] a, input logic dv,
                          input logic [31:0] d, input logic m);
    bl_if.addr_valid        = av;
    bl_if.addr              = a;
    bl_if.data_valid        = dv;
    bl_if.data              = d;
    bl_if.data_just_matched = m;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    out_ready = 1'b0;
    set_pair(1'b1, 8'hEE, 1'b1, 32'h0, 1'b0);
    tick();
    tick();
    #1;
    check_val("ack_in_reset", 64'(bl_if.ack), 64'd0);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_match_count", 64'(match_count), 64'd0);
    check_val("rst_protocol_err", 64'(protocol_err), 64'd0);
    reset = 1'b0;
    set_pair(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);

    // first pair, visible one cycle after ack
    set_pair(1'b1, 8'h12, 1'b1, 32'hDEADBEEF, 1'b0);
    #1 check_val("t1_ack", 64'(bl_if.ack), 64'd1);
    tick();
    set_pair(1'b0, 8'h12, 1'b0, 32'hDEADBEEF, 1'b0);
    check_val("t1_out_valid", 64'(out_valid), 64'd1);
    check_val("t1_out_addr", 64'(out_addr), 64'h12);
    check_val("t1_out_data", 64'(out_data), 64'hDEADBEEF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("t1_popped", 64'(out_valid), 64'd0);

    // addr_valid alone for three cycles, then data_valid joins
    set_pair(1'b1, 8'h34, 1'b0, 32'h11111111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check_val("t2_addr_only_ack", 64'(bl_if.ack), 64'd0);
      tick();
    end
    check_val("t2_nothing_stored", 64'(out_valid), 64'd0);
    bl_if.data_valid = 1'b1;
    #1 check_val("t2_ack", 64'(bl_if.ack), 64'd1);
    tick();
    set_pair(1'b0, 8'h34, 1'b0, 32'h11111111, 1'b0);
    #1 check_val("t2_ack_drop", 64'(bl_if.ack), 64'd0);
    check_val("t2_out_valid", 64'(out_valid), 64'd1);
    check_val("t2_out_addr", 64'(out_addr), 64'h34);
    check_val("t2_out_data", 64'(out_data), 64'h11111111);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("t2_single_entry", 64'(out_valid), 64'd0);

    // five back-to-back pairs into a 4-deep FIFO
    for (int i = 0; i < 4; i++) begin
      set_pair(1'b1, 8'(8'h40 + i), 1'b1, 32'(32'hA0000000 + i), 1'b0);
      #1 check_val("t3_fill_ack", 64'(bl_if.ack), 64'd1);
      tick();
    end
    set_pair(1'b1, 8'h44, 1'b1, 32'hA0000004, 1'b0);
    #1 check_val("t3_full_ack", 64'(bl_if.ack), 64'd0);
    tick();
    check_val("t3_hold_stable_addr", 64'(out_addr), 64'h40);
    #1 check_val("t3_full_ack2", 64'(bl_if.ack), 64'd0);
    out_ready = 1'b1;
    #1 check_val("t3_no_bypass", 64'(bl_if.ack), 64'd0);
    tick();
    out_ready = 1'b0;
    #1 check_val("t3_fifth_ack", 64'(bl_if.ack), 64'd1);
    tick();
    set_pair(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      check_val("t3_drain_valid", 64'(out_valid), 64'd1);
      check_val("t3_drain_addr", 64'(out_addr), 64'(8'h40 + j));
      check_val("t3_drain_data", 64'(out_data), 64'(32'hA0000000 + j));
      tick();
    end
    check_val("t3_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // count 4 -> 3 -> 4 observed through ack
    for (int i = 0; i < 4; i++) begin
      set_pair(1'b1, 8'(8'h50 + i), 1'b1, 32'(32'hB0000000 + i), 1'b0);
      tick();
    end
    set_pair(1'b1, 8'h54, 1'b1, 32'hB0000004, 1'b0);
    #1 check_val("t4_full_ack", 64'(bl_if.ack), 64'd0);
    out_ready = 1'b1;
    #1 check_val("t4_pop_cycle_ack", 64'(bl_if.ack), 64'd0);
    tick();
    out_ready = 1'b0;
    #1 check_val("t4_refill_ack", 64'(bl_if.ack), 64'd1);
    tick();
    set_pair(1'b1, 8'h55, 1'b1, 32'hB0000005, 1'b0);
    #1 check_val("t4_full_again_ack", 64'(bl_if.ack), 64'd0);
    set_pair(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      check_val("t4_drain_addr", 64'(out_addr), 64'(8'h50 + j));
      check_val("t4_drain_data", 64'(out_data), 64'(32'hB0000000 + j));
      tick();
    end
    check_val("t4_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // match counter and saturation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    set_pair(1'b1, 8'h60, 1'b1, 32'h00000006, 1'b1);
    #1 check_val("t5_ack_m1", 64'(bl_if.ack), 64'd1);
    tick();
    bl_if.data_just_matched = 1'b0;
    #1 check_val("t5_ack_m0", 64'(bl_if.ack), 64'd1);
    tick();
    bl_if.data_just_matched = 1'b1;
    #1 check_val("t5_ack_m1b", 64'(bl_if.ack), 64'd1);
    tick();
    check_val("t5_match_count", 64'(match_count), 64'd2);
    check_val("t5_stream_valid", 64'(out_valid), 64'd1);
    repeat (65532) tick();
    check_val("t5_match_fffe", 64'(match_count), 64'hFFFE);
    tick();
    check_val("t5_match_ffff", 64'(match_count), 64'hFFFF);
    repeat (5) tick();
    check_val("t5_match_saturated", 64'(match_count), 64'hFFFF);
    out_ready = 1'b0;

    // hold-rule violation and mid-stream reset
    reset = 1'b1;
    set_pair(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    tick();
    reset = 1'b0;
    set_pair(1'b1, 8'h70, 1'b0, 32'h0, 1'b0);
    #1 check_val("t6_unacked", 64'(bl_if.ack), 64'd0);
    tick();
    check_val("t6_err_clear", 64'(protocol_err), 64'd0);
    bl_if.addr = 8'h71;
    tick();
    check_val("t6_err_set", 64'(protocol_err), 64'(EXP_PERR));
    set_pair(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    check_val("t6_err_sticky", 64'(protocol_err), 64'(EXP_PERR));
    set_pair(1'b1, 8'h80, 1'b1, 32'h00000080, 1'b1);
    tick();
    set_pair(1'b1, 8'h81, 1'b1, 32'h00000081, 1'b1);
    tick();
    check_val("t6_pre_rst_valid", 64'(out_valid), 64'd1);
    check_val("t6_pre_rst_match", 64'(match_count), 64'd2);
    reset = 1'b1;
    #1 check_val("t6_ack_in_reset", 64'(bl_if.ack), 64'd0);
    tick();
    check_val("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check_val("t6_rst_match", 64'(match_count), 64'd0);
    check_val("t6_rst_perr", 64'(protocol_err), 64'd0);
    reset = 1'b0;
    set_pair(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    tick();
    check_val("t6_flushed", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/buffer_line_sink.md
# buffer_line_sink

Consumer endpoint of the buffer-line handshake. It accepts (addr, data) pairs from a buffer-line producer, acknowledges each pair, and queues the pairs in an internal FIFO. The FIFO drains through a plain valid/ready stream toward the local buffer write port. The block sits on the receiving side of every buffer-line link and is the only place a pair is acknowledged.

## Interface
Parameters:
- ADDR_WIDTH, 8: width of the line address.
- DATA_WIDTH, 32: width of the data word.
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  sole clock; everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in  consumer modport  buffer_line_interface(ADDR_WIDTH, DATA_WIDTH): addr, addr_valid, data, data_valid, data_just_matched are inputs; ack is an output.
- out_addr  out  ADDR_WIDTH  address at the FIFO head.
- out_data  out  DATA_WIDTH  data at the FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts the head entry.
- match_count  out  16  number of accepted pairs that had data_just_matched=1.
- protocol_err  out  1  sticky flag; present only with BUFFER_LINE_CHECK_EN, otherwise tied to 0.

## Operation
- A pair is accepted in a cycle where addr_valid && data_valid && !full. ack is the combinational AND of these three terms.
- On acceptance: {addr, data} is written at the write pointer and the write pointer increments, wrapping modulo DEPTH. If data_just_matched=1, match_count increments.
- match_count saturates at 16'hFFFF; it does not wrap.
- Pop: out_valid && out_ready; the read pointer increments, wrapping modulo DEPTH.
- Occupancy counter has width clog2(DEPTH)+1.
  - full = (count == DEPTH).
  - empty = (count == 0).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full, ack stays 0 even if a pop happens in the same cycle. There is no bypass, which keeps ack free of any path from out_ready.
- When empty, there is no pass-through: a pair accepted in cycle N is visible at the output in cycle N+1.
- If only one of addr_valid or data_valid is high, ack=0 and nothing is stored.
- The producer holds both sides until ack.

## Timing
- Reset values: ack=0, out_valid=0, match_count=0, protocol_err=0. Pointers and count are 0. out_addr and out_data are don't-care while out_valid=0.
- Reset asserted mid-operation flushes all FIFO contents in that cycle. ack is forced low while reset is high.
- Latency from ack to out_valid is 1 cycle.
- Sustained throughput is 1 pair per cycle while not full and out_ready is held high.
- out_addr and out_data come directly from the storage read at the read pointer; no extra register stage.
- out_addr and out_data are stable while out_valid && !out_ready.

## Configuration
- BUFFER_LINE_CHECK_EN defined: the block registers the previous cycle's addr, data and valids and checks the hold rule.
  - If addr_valid or data_valid was high and unacked in cycle N, then in cycle N+1 that valid must still be high and its payload must be unchanged.
  - A violation sets protocol_err, which stays set until reset.
- BUFFER_LINE_CHECK_EN undefined: the check logic is absent and protocol_err is the constant 0.

## Structure
- Package buffer_line_pkg holds:
  - the entry struct typedef {addr, data}, parameterized through localparams;
  - MATCH_COUNT_WIDTH = 16.
- Sub-module buffer_line_fifo is a generic synchronous FIFO with DEPTH and WIDTH parameters and push/pop/full/empty/count ports.
- buffer_line_sink instantiates buffer_line_fifo and adds the ack logic, the match counter and the optional checker.

## Test plan
- Reset, then present addr=8'h12, data=32'hDEADBEEF, both valid, out_ready=0 -> ack=1 that cycle; next cycle out_valid=1 with out_addr=8'h12, out_data=32'hDEADBEEF.
- addr_valid=1, data_valid=0 for 3 cycles, then data_valid=1 -> ack=0 for 3 cycles, then 1 for exactly one cycle; one entry stored.
- out_ready=0 and 5 back-to-back valid pairs with DEPTH=4 -> ack high for the first 4 cycles, low on the 5th; raise out_ready -> the 5th pair is acked the cycle after the first pop; entries emerge in order.
- Full FIFO with out_ready=1 and a pending valid pair -> ack=0 in the pop cycle and ack=1 in the following cycle; count goes 4->3->4.
- Accept 3 pairs with data_just_matched=1,0,1 -> match_count=2; preload match_count to 16'hFFFF via a long run -> it remains 16'hFFFF.
- With BUFFER_LINE_CHECK_EN: change addr while addr_valid=1 and ack=0 -> protocol_err=1 the next cycle and stays 1; assert reset mid-stream -> out_valid=0, match_count=0, protocol_err=0 the next cycle.
